delay_line_cfg: RTL

Runtime-configurable, stallable delay line with valid tracking: a WIDTH-bit token accepted at the input reappears at the output exactly `depth` enabled cycles later, where `depth` is reprogrammable from 1 to MAX_DEPTH without losing in-flight data. It is the parametrised successor of the fixed-latency delay register chain and aligns operands with pipelined arithmetic (modular multipliers, butterflies) whose latency depends on the selected modulus or mode. Global `en` freezes the whole line, and `flush` discards in-flight tokens.

---
 rtl/delay_line_cfg.sv | 139 +++++++++++++
 1 files changed

// File: rtl/delay_line_cfg.sv
// delay_line_cfg: stallable delay line with runtime-programmable depth.
// Depth changes drain the line first so in-flight tokens are never lost.
module delay_line_cfg #(
    parameter int WIDTH         = 32,
    parameter int MAX_DEPTH     = 16,
    parameter int DEFAULT_DEPTH = 1,
    parameter int CW            = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             flush,
    input  logic             cfg_load,
    input  logic [CW-1:0]    cfg_depth,
    output logic [CW-1:0]    depth,
    output logic [CW-1:0]    occupancy,
    output logic             cfg_done
);

    localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    logic [WIDTH-1:0]     data_q [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] vld_q;
    logic [CW-1:0]        depth_q;
    logic [CW-1:0]        pend_q;
    logic [CW-1:0]        occ_q;
    logic                 done_q;
    state_t               state_q;
    state_t               state_d;
    logic                 apply;
    logic                 accept;
    logic [CW-1:0]        tap_full;
    logic [AW-1:0]        tap;

    function automatic logic [CW-1:0] clamp(input logic [CW-1:0] d);
        if (d == '0) begin
            return CW'(1);
        end else if (d > CW'(MAX_DEPTH)) begin
            return CW'(MAX_DEPTH);
        end else begin
            return d;
        end
    endfunction

    assign in_ready  = (state_q == RUN);
    assign accept    = in_valid & in_ready & en & ~flush;
    assign tap_full  = depth_q - CW'(1);
    assign tap       = tap_full[AW-1:0];
    assign out_data  = data_q[tap];
    assign out_valid = vld_q[tap];
    assign depth     = depth_q;
    assign occupancy = occ_q;
    assign cfg_done  = done_q;

    // Next-state: drain completes on an enabled edge with no tokens left.
    always_comb begin
        state_d = state_q;
        apply   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (cfg_load) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (en && occ_q == '0) begin
                    state_d = RUN;
                    apply   = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Data chain shifts on every enabled edge regardless of valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (en) begin
            data_q[0] <= in_data;
            for (int i = 1; i < MAX_DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    // Valid chain; flush and depth switch wipe every stage.
    always_ff @(posedge clk) begin
        if (reset || flush || apply) begin
            vld_q <= '0;
        end else if (en) begin
            vld_q[0] <= accept;
            for (int i = 1; i < MAX_DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Tokens between input and tap: in on accept, out when tap is valid.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occ_q <= '0;
        end else if (en) begin
            occ_q <= occ_q + CW'(accept) - CW'(out_valid);
        end
    end

    // FSM register, pending/active depth and the one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            depth_q <= CW'(DEFAULT_DEPTH);
            pend_q  <= CW'(DEFAULT_DEPTH);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= apply;
            if (apply) begin
                depth_q <= pend_q;
            end
            if (state_q == RUN && cfg_load) begin
                pend_q <= clamp(cfg_depth);
            end
        end
    end

endmodule
